// File: rtl/sierpinski_pkg.sv
// Shared types, vertex codes and vertex coordinate helpers for the Sierpinski chaos-game core.
package sierpinski_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [1:0] CODE_V0     = 2'd0;
  localparam logic [1:0] CODE_V1     = 2'd1;
  localparam logic [1:0] CODE_V2     = 2'd2;
  localparam logic [1:0] CODE_REJECT = 2'd3;

  // Coordinates are returned 32 bits wide; callers cast to their own COORD_W.
  function automatic logic [31:0] vertex_x(input logic [1:0] code, input int unsigned coord_w);
    case (code)
      CODE_V1: vertex_x = (32'd1 << coord_w) - 32'd1;
      CODE_V2: vertex_x = 32'd1 << (coord_w - 32'd1);
      default: vertex_x = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] vertex_y(input logic [1:0] code, input int unsigned coord_w);
    case (code)
      CODE_V2: vertex_y = (32'd1 << coord_w) - 32'd1;
      default: vertex_y = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/sierpinski_midpoint.sv
// Combinational vertex select and floor-average of the current point with that vertex.
module sierpinski_midpoint
  import sierpinski_pkg::*;
#(
  parameter int unsigned COORD_W = 8
) (
  input  logic [COORD_W-1:0] cur_x_i,
  input  logic [COORD_W-1:0] cur_y_i,
  input  logic [1:0]         code_i,
  output logic [COORD_W-1:0] mid_x_o,
  output logic [COORD_W-1:0] mid_y_o
);

  logic [COORD_W-1:0] vx_s;
  logic [COORD_W-1:0] vy_s;
  logic [COORD_W:0]   sum_x_s;
  logic [COORD_W:0]   sum_y_s;

  // One extra sum bit keeps the average exact before the shift.
  always_comb begin
    vx_s    = COORD_W'(vertex_x(code_i, COORD_W));
    vy_s    = COORD_W'(vertex_y(code_i, COORD_W));
    sum_x_s = {1'b0, cur_x_i} + {1'b0, vx_s};
    sum_y_s = {1'b0, cur_y_i} + {1'b0, vy_s};
    mid_x_o = sum_x_s[COORD_W:1];
    mid_y_o = sum_y_s[COORD_W:1];
  end

endmodule

// File: rtl/sierpinski_chaos_core.sv
// Chaos-game point generator: consumes random vertex codes, emits Sierpinski points
// through a registered valid/ready output.
module sierpinski_chaos_core
  import sierpinski_pkg::*;
#(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned START_X = 64,
  parameter int unsigned START_Y = 64,
  parameter int unsigned WARMUP  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               restart,
  input  logic               rnd_valid,
  input  logic [1:0]         rnd_code,
  output logic               rnd_ready,
  output logic               pt_valid,
  output logic [COORD_W-1:0] pt_x,
  output logic [COORD_W-1:0] pt_y,
  input  logic               pt_ready,
  output logic [15:0]        pt_count
);

  localparam logic [COORD_W-1:0] START_X_C = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);
  localparam logic [15:0]        WARM_LIM  = 16'(WARMUP);

  state_e             state_q,    state_d;
  logic [COORD_W-1:0] cur_x_q,    cur_x_d;
  logic [COORD_W-1:0] cur_y_q,    cur_y_d;
  logic [15:0]        warm_cnt_q, warm_cnt_d;
  logic               pt_valid_q, pt_valid_d;
  logic [COORD_W-1:0] pt_x_q,     pt_x_d;
  logic [COORD_W-1:0] pt_y_q,     pt_y_d;
  logic [15:0]        pt_count_q, pt_count_d;

  logic [COORD_W-1:0] mid_x_s;
  logic [COORD_W-1:0] mid_y_s;
  logic               accept_s;
  logic               take_s;

  sierpinski_midpoint #(.COORD_W(COORD_W)) u_mid (
    .cur_x_i (cur_x_q),
    .cur_y_i (cur_y_q),
    .code_i  (rnd_code),
    .mid_x_o (mid_x_s),
    .mid_y_o (mid_y_s)
  );

  assign rnd_ready = en & ~restart &
                     ((state_q == ST_WARM) |
                      ((state_q == ST_RUN) & (~pt_valid_q | pt_ready)));
  assign accept_s  = pt_valid_q & pt_ready;
  // Code 3 still completes the handshake but never moves the point.
  assign take_s    = rnd_valid & rnd_ready & (rnd_code != CODE_REJECT);

  // Next-state, datapath and handshake decisions; restart overrides everything.
  always_comb begin
    state_d    = state_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    warm_cnt_d = warm_cnt_q;
    pt_valid_d = pt_valid_q;
    pt_x_d     = pt_x_q;
    pt_y_d     = pt_y_q;
    pt_count_d = pt_count_q;
    if (restart) begin
      cur_x_d    = START_X_C;
      cur_y_d    = START_Y_C;
      warm_cnt_d = 16'd0;
      pt_valid_d = 1'b0;
      if (en) begin
        state_d = (WARM_LIM != 16'd0) ? ST_WARM : ST_RUN;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      if (accept_s) begin
        pt_count_d = pt_count_q + 16'd1;
        pt_valid_d = 1'b0;
      end else begin
        pt_count_d = pt_count_q;
      end
      if (take_s) begin
        cur_x_d = mid_x_s;
        cur_y_d = mid_y_s;
        if (state_q == ST_WARM) begin
          warm_cnt_d = warm_cnt_q + 16'd1;
        end else begin
          pt_x_d     = mid_x_s;
          pt_y_d     = mid_y_s;
          pt_valid_d = 1'b1;
        end
      end else begin
        cur_x_d = cur_x_q;
      end
      if (!en) begin
        state_d = ST_IDLE;
      end else begin
        // warm_cnt survives an enable drop, so a finished warm-up resumes straight in RUN.
        case (state_q)
          ST_IDLE: state_d = (warm_cnt_q >= WARM_LIM) ? ST_RUN : ST_WARM;
          ST_WARM: begin
            if (take_s && ((warm_cnt_q + 16'd1) >= WARM_LIM)) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_WARM;
            end
          end
          ST_RUN:  state_d = ST_RUN;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_x_q    <= START_X_C;
      cur_y_q    <= START_Y_C;
      warm_cnt_q <= 16'd0;
      pt_valid_q <= 1'b0;
      pt_x_q     <= '0;
      pt_y_q     <= '0;
      pt_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      warm_cnt_q <= warm_cnt_d;
      pt_valid_q <= pt_valid_d;
      pt_x_q     <= pt_x_d;
      pt_y_q     <= pt_y_d;
      pt_count_q <= pt_count_d;
    end
  end

  assign pt_valid = pt_valid_q;
  assign pt_x     = pt_x_q;
  assign pt_y     = pt_y_q;
  assign pt_count = pt_count_q;

endmodule

// File: tb/tb_sierpinski_chaos_core.sv
// Directed table-driven bench for sierpinski_chaos_core (COORD_W=8, WARMUP=2, start 64,64).
module tb_sierpinski_chaos_core;

  typedef struct {
    logic        en;
    logic        rs;
    logic        rv;
    logic [1:0]  code;
    logic        pr;
    logic        e_rdy;
    logic        e_val;
    logic [7:0]  e_x;
    logic [7:0]  e_y;
    logic [15:0] e_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic        rnd_valid = 1'b0;
  logic [1:0]  rnd_code = 2'd0;
  logic        rnd_ready;
  logic        pt_valid;
  logic [7:0]  pt_x;
  logic [7:0]  pt_y;
  logic        pt_ready = 1'b0;
  logic [15:0] pt_count;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  sierpinski_chaos_core #(
    .COORD_W (8),
    .START_X (64),
    .START_Y (64),
    .WARMUP  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .restart   (restart),
    .rnd_valid (rnd_valid),
    .rnd_code  (rnd_code),
    .rnd_ready (rnd_ready),
    .pt_valid  (pt_valid),
    .pt_x      (pt_x),
    .pt_y      (pt_y),
    .pt_ready  (pt_ready),
    .pt_count  (pt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8:1];
  endfunction

  task automatic add(input logic en_v, input logic rs_v, input logic rv_v, input logic [1:0] c,
                     input logic pr_v, input logic rdy, input logic val, input logic [7:0] x,
                     input logic [7:0] y, input logic [15:0] cnt);
    vec_t v;
    v.en = en_v; v.rs = rs_v; v.rv = rv_v; v.code = c; v.pr = pr_v;
    v.e_rdy = rdy; v.e_val = val; v.e_x = x; v.e_y = y; v.e_cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] mx, my, vx, vy;
    logic [1:0] c;

    // en rs rv code pr | rdy val x y cnt
    add(1,0,0,2'd0,0, 0,0,  0,  0,0);   // IDLE -> WARM
    add(1,0,1,2'd1,1, 1,0,  0,  0,0);   // warm: (159,32)
    add(1,0,1,2'd2,1, 1,0,  0,  0,0);   // warm: (143,143)
    add(1,0,1,2'd0,1, 1,1, 71, 71,0);   // first point
    add(1,0,0,2'd0,1, 1,0, 71, 71,1);   // accepted
    add(1,0,1,2'd3,1, 1,0, 71, 71,1);   // reject code
    add(1,0,1,2'd1,1, 1,1,163, 35,1);
    for (int i = 0; i < 5; i++) add(1,0,1,2'd2,0, 0,1,163,35,1);  // backpressure
    add(1,0,0,2'd0,1, 1,0,163, 35,2);   // single accept
    add(1,0,1,2'd2,0, 1,1,145,145,2);
    add(1,1,1,2'd2,0, 0,0,145,145,2);   // restart drops pending point
    add(1,0,1,2'd0,1, 1,0,145,145,2);   // warm: (32,32)
    add(1,0,1,2'd0,1, 1,0,145,145,2);   // warm: (16,16)
    add(1,0,1,2'd1,1, 1,1,135,  8,2);
    add(0,0,1,2'd2,0, 0,1,135,  8,2);   // enable drop
    add(0,0,1,2'd2,1, 0,0,135,  8,3);   // accept still allowed in IDLE
    add(1,0,1,2'd2,1, 0,0,135,  8,3);   // IDLE -> RUN, no warm-up
    add(1,0,1,2'd2,1, 1,1,131,131,3);
    add(1,0,0,2'd0,1, 1,0,131,131,4);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 40'(pt_valid), 40'd0);
    chk("rst_xy",    40'({pt_x, pt_y}), 40'd0);
    chk("rst_count", 40'(pt_count), 40'd0);
    chk("rst_ready", 40'(rnd_ready), 40'd0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      en = vecs[k].en; restart = vecs[k].rs; rnd_valid = vecs[k].rv;
      rnd_code = vecs[k].code; pt_ready = vecs[k].pr;
      #1;
      chk($sformatf("v%0d_ready", k), 40'(rnd_ready), 40'(vecs[k].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out", k), {7'd0, pt_valid, pt_x, pt_y, pt_count},
          {7'd0, vecs[k].e_val, vecs[k].e_x, vecs[k].e_y, vecs[k].e_cnt});
    end

    // Async reset between edges with a point pending.
    en = 1'b1; restart = 1'b0; rnd_valid = 1'b1; rnd_code = 2'd0; pt_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_pt", {7'd0, pt_valid, pt_x, pt_y, pt_count}, {7'd0, 1'b1, 8'd65, 8'd65, 16'd4});
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 40'(pt_valid), 40'd0);
    chk("async_rst_count", 40'(pt_count), 40'd0);
    chk("async_rst_ready", 40'(rnd_ready), 40'd0);
    en = 1'b0; rnd_valid = 1'b0; pt_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Throughput and count wrap: one point per cycle with continuous codes.
    en = 1'b1;
    @(posedge clk);
    #1;
    mx = 8'd64; my = 8'd64;
    rnd_valid = 1'b1; pt_ready = 1'b1;
    for (int i = 0; i <= 65538; i++) begin
      c = 2'(i % 3);
      rnd_code = c;
      vx = (c == 2'd1) ? 8'd255 : ((c == 2'd2) ? 8'd128 : 8'd0);
      vy = (c == 2'd2) ? 8'd255 : 8'd0;
      mx = avg(mx, vx);
      my = avg(my, vy);
      #1;
      if (rnd_ready !== 1'b1) begin
        chk($sformatf("thru_ready_%0d", i), 40'(rnd_ready), 40'd1);
      end
      @(posedge clk);
      #1;
      if (i >= 2) begin
        chk("thru_pt", {7'd0, pt_valid, pt_x, pt_y, pt_count},
            {7'd0, 1'b1, mx, my, 16'(i - 2)});
      end else begin
        chk("warm_no_out", 40'(pt_valid), 40'd0);
      end
      if (i == 65537) chk("count_max", 40'(pt_count), 40'hFFFF);
    end
    chk("count_wrap", 40'(pt_count), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
